// File: rtl/flip_sweep_checker.sv
// Sweeps every WIDTH-bit pattern into a row of Flip inverter lanes and checks
// that each lane returns the inverse of its input after a settle window.
module flip_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] err_vec
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0]     WLOAD    = 4'(SETTLE - 1);
  localparam logic [WIDTH:0] PAT_LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] PAT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH:0]   pat;
  logic [3:0]       wcnt;

  logic [WIDTH:0]   pat_next;
  logic [WIDTH-1:0] mism;
  logic [WIDTH-1:0] vec_next;
  logic [7:0]       cnt_next;

  // Lane result evaluated against the pattern currently on x; only used in CHECK.
  assign pat_next = pat + PAT_ONE;
  assign mism     = y ^ ~x;
  assign vec_next = err_vec | mism;
  assign cnt_next = ((|mism) && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      err_vec   <= '0;
      pat       <= '0;
      wcnt      <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          x    <= '0;
          busy <= 1'b0;
          if (start) begin
            err_count <= 8'd0;
            err_vec   <= '0;
            pass      <= 1'b0;
            pat       <= '0;
            wcnt      <= WLOAD;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) state <= CHECK;
          else              wcnt  <= wcnt - 4'd1;
        end
        CHECK: begin
          err_vec   <= vec_next;
          err_count <= cnt_next;
          if (pat == PAT_LAST) begin
            // Verdict is registered with the done pulse so it is valid in that cycle.
            pass  <= (cnt_next == 8'd0) && (vec_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            x     <= '0;
            state <= DONE;
          end else begin
            pat   <= pat_next;
            x     <= pat_next[WIDTH-1:0];
            wcnt  <= WLOAD;
            state <= WAIT;
          end
        end
        DONE: begin
          x     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flip_sweep_checker.sv
// Bench for flip_sweep_checker: four instances with different lane behaviours,
// an arithmetic sweep model checked every cycle, plus literal expectations.
module tb_flip_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] start_s = 4'b0000;
  logic [3:0] rst_s   = 4'b1111;
  logic       stuck   = 1'b0;

  // inst0: W2 S1, good or y[1] stuck at 0
  logic [1:0] x0, y0, v0; logic b0, d0, p0; logic [7:0] c0;
  // inst1: W2 S3, good lanes
  logic [1:0] x1, y1, v1; logic b1, d1, p1; logic [7:0] c1;
  // inst2: W8 S1, y wired straight to x (every lane wrong)
  logic [7:0] x2, y2, v2; logic b2, d2, p2; logic [7:0] c2;
  // inst3: W1 S2, inverter with one cycle of extra delay
  logic [0:0] x3, v3; logic [0:0] y3 = 1'b1; logic b3, d3, p3; logic [7:0] c3;

  assign y0 = stuck ? (~x0 & 2'b01) : ~x0;
  assign y1 = ~x1;
  assign y2 = x2;
  always @(posedge clk) y3 <= ~x3;

  flip_sweep_checker #(.WIDTH(2), .SETTLE(1)) u0 (.clk(clk), .rst(rst_s[0]), .start(start_s[0]),
    .x(x0), .y(y0), .busy(b0), .done(d0), .pass(p0), .err_count(c0), .err_vec(v0));
  flip_sweep_checker #(.WIDTH(2), .SETTLE(3)) u1 (.clk(clk), .rst(rst_s[1]), .start(start_s[1]),
    .x(x1), .y(y1), .busy(b1), .done(d1), .pass(p1), .err_count(c1), .err_vec(v1));
  flip_sweep_checker #(.WIDTH(8), .SETTLE(1)) u2 (.clk(clk), .rst(rst_s[2]), .start(start_s[2]),
    .x(x2), .y(y2), .busy(b2), .done(d2), .pass(p2), .err_count(c2), .err_vec(v2));
  flip_sweep_checker #(.WIDTH(1), .SETTLE(2)) u3 (.clk(clk), .rst(rst_s[3]), .start(start_s[3]),
    .x(x3), .y(y3), .busy(b3), .done(d3), .pass(p3), .err_count(c3), .err_vec(v3));

  wire [3:0] done_all = {d3, d2, d1, d0};

  int checks = 0;
  int errors = 0;
  int n = 0;

  localparam int NONE = -1000000;
  int wi[4] = '{2, 2, 8, 1};
  int si[4] = '{1, 3, 1, 2};
  int s0[4] = '{NONE, NONE, NONE, NONE};
  int fin_cnt[4], fin_vec[4], fin_pass[4];
  int hld_cnt[4] = '{0, 0, 0, 0};
  int hld_vec[4] = '{0, 0, 0, 0};
  int hld_pass[4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", nm, n, act, exp);
    end
  endtask

  // What a lane returns for pattern p once settled.
  function automatic int lane(input int i, input int p);
    int mask = (1 << wi[i]) - 1;
    case (i)
      0:       lane = stuck ? (~p & 1) : (~p & mask);
      2:       lane = p;
      default: lane = ~p & mask;
    endcase
  endfunction

  task automatic model_sweep(input int i);
    int mask = (1 << wi[i]) - 1;
    int cnt = 0, vec = 0, m;
    for (int p = 0; p < (1 << wi[i]); p++) begin
      m = (lane(i, p) ^ (~p & mask)) & mask;
      vec |= m;
      if (m != 0) cnt++;
    end
    fin_cnt[i]  = (cnt > 255) ? 255 : cnt;
    fin_vec[i]  = vec;
    fin_pass[i] = (cnt == 0 && vec == 0) ? 1 : 0;
  endtask

  // Per-edge compare against the sweep model.
  initial begin
    int xa, ba, da, pa, ca, va, len, k;
    forever begin
      @(posedge clk);
      n++;
      #1;
      for (int i = 0; i < 4; i++) begin
        case (i)
          0: begin xa = int'(x0); ba = int'(b0); da = int'(d0); pa = int'(p0); ca = int'(c0); va = int'(v0); end
          1: begin xa = int'(x1); ba = int'(b1); da = int'(d1); pa = int'(p1); ca = int'(c1); va = int'(v1); end
          2: begin xa = int'(x2); ba = int'(b2); da = int'(d2); pa = int'(p2); ca = int'(c2); va = int'(v2); end
          default: begin xa = int'(x3); ba = int'(b3); da = int'(d3); pa = int'(p3); ca = int'(c3); va = int'(v3); end
        endcase
        len = (1 << wi[i]) * (si[i] + 1);
        if (rst_s[i]) begin
          s0[i] = NONE;
          hld_cnt[i] = 0; hld_vec[i] = 0; hld_pass[i] = 0;
        end else if (start_s[i] && (s0[i] == NONE || (n - 1 - s0[i]) >= len + 2)) begin
          s0[i] = n - 1;
          model_sweep(i);
        end
        k = (s0[i] == NONE) ? len + 100 : n - s0[i];
        if (k >= 1 && k <= len) begin
          chk("m_x", xa, (k - 1) / (si[i] + 1));
          chk("m_busy", ba, 1);
          chk("m_done", da, 0);
          chk("m_pass_sweep", pa, 0);
        end else begin
          if (k == len + 1) begin
            hld_cnt[i] = fin_cnt[i]; hld_vec[i] = fin_vec[i]; hld_pass[i] = fin_pass[i];
          end
          chk("m_x", xa, 0);
          chk("m_busy", ba, 0);
          chk("m_done", da, (k == len + 1) ? 1 : 0);
          chk("m_pass", pa, hld_pass[i]);
          chk("m_cnt", ca, hld_cnt[i]);
          chk("m_vec", va, hld_vec[i]);
        end
      end
    end
  end

  // Raise start for one cycle and count cycles until done, sampled at negedge.
  task automatic run(input int i, input int bound, output int lat);
    @(negedge clk);
    start_s[i] = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) start_s[i] = 1'b0;
      if (done_all[i]) break;
      if (lat > bound) begin
        chk("done_timeout", lat, -1);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ex_x[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    repeat (2) @(negedge clk);
    chk("rst_x", int'(x0), 0);
    chk("rst_busy", int'(b2), 0);
    rst_s = 4'b0000;
    repeat (2) @(negedge clk);

    // Good lanes, W2 S1: literal cycle-by-cycle trace
    start_s[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      chk("t1_x", int'(x0), ex_x[c - 1]);
      chk("t1_busy", int'(b0), (c <= 8) ? 1 : 0);
      chk("t1_done", int'(d0), (c == 9) ? 1 : 0);
    end
    chk("t1_pass", int'(p0), 1);
    chk("t1_cnt", int'(c0), 0);
    chk("t1_vec", int'(v0), 0);
    repeat (3) @(negedge clk);

    // Stuck lane y[1]=0
    stuck = 1'b1;
    run(0, 40, lat);
    chk("stuck_lat", lat, 9);
    chk("stuck_pass", int'(p0), 0);
    chk("stuck_cnt", int'(c0), 2);
    chk("stuck_vec", int'(v0), 2);
    repeat (3) @(negedge clk);
    stuck = 1'b0;

    // Start while busy and on the done cycle is ignored
    @(negedge clk);
    start_s[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start_s[0] = (c == 4 || c == 9) ? 1'b1 : 1'b0;
      if (c == 9) chk("rej_done", int'(d0), 1);
      if (c == 8) chk("rej_busy8", int'(b0), 1);
      if (c >= 10) chk("rej_idle", int'(b0), 0);
    end
    chk("rej_pass", int'(p0), 1);

    // Reset mid-sweep, W2 S3
    @(negedge clk);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (9) @(negedge clk);
    rst_s[1] = 1'b1;
    @(negedge clk);
    rst_s[1] = 1'b0;
    chk("mrst_x", int'(x1), 0);
    chk("mrst_busy", int'(b1), 0);
    chk("mrst_cnt", int'(c1), 0);
    chk("mrst_done", int'(d1), 0);
    repeat (2) @(negedge clk);
    run(1, 60, lat);
    chk("mrst_lat", lat, 17);
    chk("mrst_pass", int'(p1), 1);
    repeat (3) @(negedge clk);

    // Saturation, W8 S1, every lane wrong
    run(2, 600, lat);
    chk("sat_lat", lat, 513);
    chk("sat_cnt", int'(c2), 255);
    chk("sat_vec", int'(v2), 255);
    chk("sat_pass", int'(p2), 0);
    repeat (3) @(negedge clk);

    // Delayed lane, W1 S2
    run(3, 40, lat);
    chk("dly_lat", lat, 7);
    chk("dly_pass", int'(p3), 1);
    chk("dly_cnt", int'(c3), 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flip_sweep_checker.md
# flip_sweep_checker

Stimulus-and-check stage wrapped around an array of `Flip` inverter lanes. On `start` it drives every input pattern of a `WIDTH`-bit bus into the lanes and samples the lane outputs after a programmable settle time. It checks each sample against the bitwise inverse of the driven pattern and reports pass/fail, a per-lane sticky error vector and a saturating mismatch count. The block sits directly upstream of the `Flip` lanes, driving their `x` inputs, and directly downstream of them, consuming their `y` outputs.

## Interface
- `WIDTH`, 2: number of `Flip` lanes; legal range 1..8.
- `SETTLE`, 1: cycles the pattern is held before sampling; legal range 1..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a sweep; sampled only in IDLE.
- `x` out `WIDTH`: pattern driven to the lane inputs (registered).
- `y` in `WIDTH`: lane outputs; expected value is `~x`.
- `busy` out 1: high while a sweep is in progress (WAIT and CHECK states).
- `done` out 1: one-cycle pulse when a sweep completes.
- `pass` out 1: 1 when the last sweep had zero mismatches; held until the next accepted `start`.
- `err_count` out 8: number of patterns with any mismatch; saturates at 255.
- `err_vec` out `WIDTH`: sticky OR of the mismatching lanes over the sweep.

## Operation
- States: IDLE, WAIT, CHECK, DONE. Internal counters:
  - `pat`: `WIDTH`+1 bits.
  - `wcnt`: 4 bits.
- IDLE:
  - `x`=0, `busy`=0.
  - If `start`=1: clear `err_count`, `err_vec` and `pass`; set `pat`=0, `x`=0, `wcnt`=`SETTLE`-1; go to WAIT.
- WAIT:
  - `x` is held.
  - If `wcnt`==0, go to CHECK; otherwise decrement `wcnt`.
- CHECK:
  - Compute `m` = `y` XOR ~`x` (1 = lane wrong).
  - `err_vec` |= `m`.
  - If `m`!=0 and `err_count`<255, increment `err_count`.
  - If `pat`==2^`WIDTH`-1: go to DONE.
  - Otherwise: `pat`+1, `x`=`pat`+1 (low `WIDTH` bits), `wcnt`=`SETTLE`-1, go to WAIT.
- DONE:
  - `done`=1 and `busy`=0.
  - `pass` = (`err_count`==0 and `err_vec`==0).
  - `x` returns to 0; go to IDLE.
- `start` outside IDLE is ignored. This includes the DONE cycle, so back-to-back sweeps need `start` high in or after the following IDLE cycle.
- `y` is sampled only in CHECK; changes on `y` at other times have no effect.
- Arithmetic:
  - `pat` compare is done at `WIDTH`+1 bits, so `WIDTH`=8 terminates at 255 without wrap.
  - `err_count` increments at most once per pattern.

## Timing
- Reset values:
  - State IDLE.
  - `x`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `err_vec`=0.
- `rst` mid-sweep: on the next edge every output takes its reset value and the sweep is abandoned; no `done` pulse.
- Start accepted at edge E0:
  - `busy` rises in the cycle after E0.
  - Each pattern occupies `SETTLE`+1 cycles (`SETTLE` WAIT cycles + 1 CHECK cycle).
  - `x` changes only at the edge leaving CHECK.
- `busy` duration = 2^`WIDTH`·(`SETTLE`+1) cycles.
- `done` is high for exactly the cycle after the last CHECK.
- `pass`, `err_count` and `err_vec` are final and stable from the `done` cycle onward.
- Start-to-done latency = 2^`WIDTH`·(`SETTLE`+1)+1 cycles.
- Lane path: the `Flip` lanes are combinational, so `y` must be valid within `SETTLE` cycles of `x` changing. The minimum `SETTLE`=1 samples one full cycle after `x` updates.

## Test plan
- Good lanes, `WIDTH`=2, `SETTLE`=1, pulse `start` at cycle 0:
  - `busy` is high cycles 1–8.
  - `x` = 0,0,1,1,2,2,3,3.
  - `done` pulses at cycle 9 with `pass`=1, `err_count`=0, `err_vec`=2'b00.
- Stuck lane, `WIDTH`=2, `y[1]` tied 0:
  - Mismatches occur on patterns 0 and 1.
  - At `done`: `pass`=0, `err_count`=2, `err_vec`=2'b10.
- Busy and DONE-cycle start rejection, `WIDTH`=2:
  - Re-assert `start` at cycle 4 and again on the `done` cycle → no restart.
  - The sweep still completes with the original 9-cycle latency, and the block returns to IDLE with `busy`=0.
- Reset mid-sweep, `WIDTH`=2, `SETTLE`=3:
  - Assert `rst` at cycle 10 → next cycle `x`=0, `busy`=0, `err_count`=0, no `done`.
  - A fresh `start` then completes in 4·4+1=17 cycles.
- Saturation, `WIDTH`=8, `SETTLE`=1, `y` wired to `x` (every lane wrong on every pattern):
  - `done` at cycle 513.
  - `err_count`=255 (saturated, not wrapped), `err_vec`=8'hFF, `pass`=0.
- `SETTLE`=2, `WIDTH`=1, lane with one cycle of extra delay on `y`:
  - `pass`=1, showing that sampling happens after the full settle window.
